seg7_digit_scanner: RTL
=======================

# seg7_digit_scanner

Time-multiplexed 4-digit scanner that sits directly upstream of the binary-to-7-segment decoder. It holds a 16-bit packed BCD value and presents one 4-bit digit at a time on `digit_bin`, which feeds the decoder's binary input. Each digit is shown for a programmable number of clock cycles, and the matching one-hot digit enable is driven on `digit_sel`. New values are accepted through a load strobe and applied only at frame boundaries, so a displayed number never tears.

## Interface
- `TICK_DIV`, default 50000: clock cycles each digit is displayed; legal range ≥ 2; prescaler width is $clog2(TICK_DIV).
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load` in 1: one-cycle strobe; captures `bcd_in`.
- `bcd_in` in 16: packed BCD; [3:0] is digit 0 (least significant), [15:12] is digit 3.
- `digit_bin` out 4: current digit value, driven to the decoder input.
- `digit_sel` out 4: one-hot digit enable, active-high; bit n enables digit n.
- `upd_ack` out 1: one-cycle pulse when a loaded value becomes the displayed value.

## Operation
- State:
  - prescaler `pcnt` (0..TICK_DIV-1)
  - digit index `idx` (0..3)
  - shadow register `shd[15:0]`
  - display register `dsp[15:0]`
  - flag `pend`
- `pcnt` increments every cycle. At `TICK_DIV-1` ("tick") it wraps to 0 and `idx` advances by 1, wrapping 3→0.
- Frame boundary: a tick while `idx==3`.
- `load` outside a boundary cycle: `shd<=bcd_in`, `pend<=1`. If a load is already pending, the new value overwrites it (last load wins); only one `upd_ack` is produced.
- Boundary with `pend==1` and no `load`: `dsp<=shd`, `pend<=0`, `upd_ack` asserted for the next cycle.
- Boundary coinciding with `load`: `dsp<=bcd_in` directly, `pend<=0`, single `upd_ack`; `shd` also takes `bcd_in`.
- Boundary with no pending value and no `load`: `dsp` unchanged, no `upd_ack`.
- Digit outputs:
  - `digit_sel = 1<<idx`.
  - `digit_bin = dsp[4*idx+3 : 4*idx]`, unless blanked (see Configuration).
- Nibbles 10–15 in `bcd_in` are not checked and pass through unchanged. The downstream decoder shows all segments off for them.
- Blanking code is 4'hF, which the decoder renders as dark. `digit_sel` stays asserted during a blanked digit.

## Timing
- Reset (asynchronous, immediate on `rst_n` falling):
  - `pcnt=0`, `idx=0`, `shd=0`, `dsp=0`, `pend=0`
  - outputs: `digit_sel=4'b0001`, `digit_bin=0`, `upd_ack=0`
- After reset release, the first tick occurs on the TICK_DIV-th rising edge.
- Reset asserted mid-frame or while a load is pending: the pending value is discarded, and scanning restarts at digit 0 with `dsp=0`.
- `digit_sel` and `digit_bin` are decoded only from registered `idx` and `dsp`. There is no combinational path from `load` or `bcd_in`.
- Both outputs change in the cycle after the tick edge, together with `idx`. Each digit is held exactly TICK_DIV cycles, so one frame is 4·TICK_DIV cycles.
- `upd_ack` is registered and high for exactly one cycle, aligned with the first cycle in which digit 0 of the new `dsp` is displayed.
- `load` is sampled every cycle. Holding it high for several cycles is equivalent to repeated loads, and the last sampled value wins.

## Configuration
- Macro: `SEG7_LZ_BLANK_EN`.
- Defined (leading-zero blanking):
  - digit 3 is blanked if `dsp[15:12]==0`
  - digit 2 is blanked if `dsp[15:8]==0`
  - digit 1 is blanked if `dsp[15:4]==0`
  - digit 0 is never blanked, so a value of zero shows a single "0"
  - blanked digits drive `digit_bin=4'hF`
- Undefined: no blanking logic is present, and every digit drives its `dsp` nibble.

## Test plan
All scenarios use TICK_DIV=4.
- **Reset mid-scan:** with `idx=2` and a load pending, pull `rst_n` low between clock edges → outputs immediately become `digit_sel=0001`, `digit_bin=0`, `upd_ack=0`. After release, the pending value is never displayed.
- **Scan order:** load 0x1234 and wait for the boundary → `upd_ack` pulses once. The following frame shows `digit_sel` 0001, 0010, 0100, 1000 with `digit_bin` 4, 3, 2, 1 respectively, each held 4 cycles, and the frame repeats every 16 cycles.
- **Tear-free update:** while 0x1234 is displayed, load 0x5678 during `idx=1` → digits 1–3 of the current frame still show 3, 2, 1. At the boundary `upd_ack` pulses, and the next frame shows 8, 7, 6, 5.
- **Back-to-back loads:** load 0x1111 then 0x2222 within one frame → exactly one `upd_ack`, and the next frame shows 2, 2, 2, 2. The value 0x1111 never appears.
- **Load on boundary:** strobe `load` with 0x9876 in the boundary cycle → the next frame shows 6, 7, 8, 9, with a single `upd_ack` and `pend==0` afterwards.
- **Leading-zero blanking:**
  - With `SEG7_LZ_BLANK_EN`: 0x0042 shows 2, 4, F, F; 0x0000 shows 0, F, F, F; 0x1000 shows 0, 0, 0, 1.
  - Without the macro: 0x0042 shows 2, 4, 0, 0.

Source files
------------

// File: rtl/seg7_digit_scanner.sv
// seg7_digit_scanner: time-multiplexed 4-digit BCD scanner feeding a 7-segment decoder.
// Each digit is shown for TICK_DIV cycles. New values are staged in a shadow register
// and only reach the display register at a frame boundary, so a number never tears.
// Optional leading-zero blanking is built when SEG7_LZ_BLANK_EN is defined.
module seg7_digit_scanner #(
  parameter int TICK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] bcd_in,
  output logic [3:0]  digit_bin,
  output logic [3:0]  digit_sel,
  output logic        upd_ack
);

  localparam int            PW   = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    idx_q,  idx_d;
  logic [15:0]   shd_q,  shd_d;
  logic [15:0]   dsp_q,  dsp_d;
  logic          pend_q, pend_d;
  logic          ack_q,  ack_d;

  logic          tick;
  logic          bnd;
  logic [3:0]    nib;

  assign tick = (pcnt_q == PMAX);
  assign bnd  = tick && (idx_q == 2'd3);

  // Next state: prescaler/digit advance and the shadow-to-display handoff at frame boundaries
  always_comb begin
    pcnt_d = tick ? '0 : pcnt_q + PW'(1);
    idx_d  = tick ? idx_q + 2'd1 : idx_q;
    shd_d  = shd_q;
    dsp_d  = dsp_q;
    pend_d = pend_q;
    ack_d  = 1'b0;
    if (bnd) begin
      if (load) begin
        // A load landing exactly on the boundary bypasses the shadow stage
        dsp_d  = bcd_in;
        shd_d  = bcd_in;
        pend_d = 1'b0;
        ack_d  = 1'b1;
      end else if (pend_q) begin
        dsp_d  = shd_q;
        pend_d = 1'b0;
        ack_d  = 1'b1;
      end
    end else if (load) begin
      // Last load before the boundary wins
      shd_d  = bcd_in;
      pend_d = 1'b1;
    end
  end

  // State registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      idx_q  <= 2'd0;
      shd_q  <= 16'h0000;
      dsp_q  <= 16'h0000;
      pend_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
      shd_q  <= shd_d;
      dsp_q  <= dsp_d;
      pend_q <= pend_d;
      ack_q  <= ack_d;
    end
  end

  // Digit nibble select, decoded only from registered index and display value
  always_comb begin
    nib = 4'h0;
    case (idx_q)
      2'd0:    nib = dsp_q[3:0];
      2'd1:    nib = dsp_q[7:4];
      2'd2:    nib = dsp_q[11:8];
      default: nib = dsp_q[15:12];
    endcase
  end

`ifdef SEG7_LZ_BLANK_EN
  logic blank;

  // Leading-zero blanking; digit 0 always shows so zero renders as a single "0"
  always_comb begin
    blank = 1'b0;
    case (idx_q)
      2'd3:    blank = (dsp_q[15:12] == 4'h0);
      2'd2:    blank = (dsp_q[15:8]  == 8'h00);
      2'd1:    blank = (dsp_q[15:4]  == 12'h000);
      default: blank = 1'b0;
    endcase
  end

  assign digit_bin = blank ? 4'hF : nib;
`else
  assign digit_bin = nib;
`endif

  assign digit_sel = 4'b0001 << idx_q;
  assign upd_ack   = ack_q;

endmodule
